// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: sequenced left/right audio mixer, one source per clock, saturated 11-bit output
//   clk, mrst (async active-high) | sample_tick starts a mix | pan gates each source left/right
//   ay1_*/ay2_*/beeper/specdrum: 8-bit unsigned levels | midi_left/right: 16-bit two's complement
//   out_left/out_right: saturated sums | out_valid: result pulse | busy: mix in progress | overrun: dropped tick
module audio_mix_sequencer #(
    parameter int NSTEPS = 9,
    parameter int SATMAX = 2047
) (
    input  logic        clk,
    input  logic        mrst,
    input  logic        sample_tick,
    input  logic [7:0]  pan,
    input  logic [7:0]  ay1_cha,
    input  logic [7:0]  ay1_chb,
    input  logic [7:0]  ay1_chc,
    input  logic [7:0]  ay2_cha,
    input  logic [7:0]  ay2_chb,
    input  logic [7:0]  ay2_chc,
    input  logic [7:0]  beeper,
    input  logic [7:0]  specdrum,
    input  logic [15:0] midi_left,
    input  logic [15:0] midi_right,
    output logic [10:0] out_left,
    output logic [10:0] out_right,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    localparam logic [3:0]  LAST  = 4'(NSTEPS - 1);
    localparam logic [12:0] SAT13 = 13'(SATMAX);
    state_t      state;
    logic [3:0]  step;
    logic [12:0] acc_l, acc_r;
    logic        pending;
    logic [7:0]  pan_q;
    logic [8:0]  lvl_q [8];
    logic [10:0] mid_l_q, mid_r_q;
    logic [1:0]  pidx;
    logic [7:0]  pan_sh;
    logic [10:0] term_l, term_r;
    logic        unused_midi;
    assign unused_midi = ^{midi_left[4:0], midi_right[4:0]};
    // PSG steps 0-5 cycle through pan pairs A,B,C; steps 6-8 share the last pair
    assign pidx   = step >= 4'd6 ? 2'd3 : step >= 4'd3 ? 2'(step - 4'd3) : step[1:0];
    assign pan_sh = pan_q << {pidx, 1'b0};
    assign term_l = pan_sh[7] ? (step == LAST ? mid_l_q : {2'b0, lvl_q[step[2:0]]}) : '0;
    assign term_r = pan_sh[6] ? (step == LAST ? mid_r_q : {2'b0, lvl_q[step[2:0]]}) : '0;
    always_ff @(posedge clk or posedge mrst) begin
        if (mrst) begin
            state     <= IDLE;
            step      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
            pan_q     <= '0;
            mid_l_q   <= '0;
            mid_r_q   <= '0;
            for (int i = 0; i < 8; i++) lvl_q[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            if (sample_tick && state != IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            case (state)
                IDLE: if (sample_tick || pending) begin
                    pan_q    <= pan;
                    lvl_q[0] <= {1'b0, ay1_cha};
                    lvl_q[1] <= {1'b0, ay1_chb};
                    lvl_q[2] <= {1'b0, ay1_chc};
                    lvl_q[3] <= {1'b0, ay2_cha};
                    lvl_q[4] <= {1'b0, ay2_chb};
                    lvl_q[5] <= {1'b0, ay2_chc};
                    lvl_q[6] <= {beeper, beeper[7]};
                    lvl_q[7] <= {specdrum, specdrum[7]};
                    // offset-binary: flip the sign bit so silence sits mid-scale
                    mid_l_q  <= midi_left[15:5] ^ 11'h400;
                    mid_r_q  <= midi_right[15:5] ^ 11'h400;
                    acc_l    <= '0;
                    acc_r    <= '0;
                    step     <= '0;
                    pending  <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ACC;
                end
                ACC: begin
                    acc_l <= acc_l + 13'(term_l);
                    acc_r <= acc_r + 13'(term_r);
                    step  <= step + 4'd1;
                    state <= step == LAST ? OUT : ACC;
                end
                OUT: begin
                    out_left  <= acc_l > SAT13 ? 11'(SATMAX) : acc_l[10:0];
                    out_right <= acc_r > SAT13 ? 11'(SATMAX) : acc_r[10:0];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// tb_audio_mix_sequencer: directed self-checking bench for audio_mix_sequencer
module tb_audio_mix_sequencer;
    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [7:0]  pan = '0;
    logic [7:0]  ay1_cha = '0, ay1_chb = '0, ay1_chc = '0;
    logic [7:0]  ay2_cha = '0, ay2_chb = '0, ay2_chc = '0;
    logic [7:0]  beeper = '0, specdrum = '0;
    logic [15:0] midi_left = 16'h8000, midi_right = 16'h8000;
    logic [10:0] out_left, out_right;
    logic        out_valid, busy, overrun;
    int checks = 0;
    int errors = 0;
    audio_mix_sequencer dut (
        .clk(clk), .mrst(mrst), .sample_tick(sample_tick), .pan(pan),
        .ay1_cha(ay1_cha), .ay1_chb(ay1_chb), .ay1_chc(ay1_chc),
        .ay2_cha(ay2_cha), .ay2_chb(ay2_chb), .ay2_chc(ay2_chc),
        .beeper(beeper), .specdrum(specdrum),
        .midi_left(midi_left), .midi_right(midi_right),
        .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask
    task automatic clear_src();
        {ay1_cha, ay1_chb, ay1_chc, ay2_cha, ay2_chb, ay2_chc, beeper, specdrum} = '0;
        midi_left  = 16'h8000;
        midi_right = 16'h8000;
    endtask
    task automatic mix(input string tag, input bit clobber, input int el, input int er);
        int lat, nb;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        if (clobber) begin
            pan     = '0;
            ay1_cha = '0;
        end
        lat = 0;
        nb  = 0;
        while (!out_valid && lat < 20) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 10);
        chk({tag, ".busy_cycles"}, nb, 10);
        chk({tag, ".left"}, out_left, el);
        chk({tag, ".right"}, out_right, er);
        @(negedge clk);
        chk({tag, ".valid_pulse"}, out_valid, 0);
    endtask
    initial begin
        int nv, first_v, second_v, nov, ov_at;
        repeat (2) @(negedge clk);
        chk("rst.left", out_left, 0);
        chk("rst.right", out_right, 0);
        chk("rst.valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.overrun", overrun, 0);
        mrst = 1'b0;
        @(negedge clk);
        pan = 8'b10_01_11_11;
        ay1_cha = 100; ay2_cha = 50; ay1_chb = 20; ay1_chc = 10;
        mix("basic", 0, 160, 30);
        clear_src();
        pan = 8'h03; beeper = 8'h80;
        mix("beep_both", 0, 257, 257);
        pan = 8'h02;
        mix("beep_left", 0, 257, 0);
        pan = 8'hFF;
        {ay1_cha, ay1_chb, ay1_chc, ay2_cha, ay2_chb, ay2_chc, beeper, specdrum} = {8{8'hFF}};
        midi_left = 16'hFFFF; midi_right = 16'hFFFF;
        mix("sat", 0, 2047, 2047);
        clear_src();
        beeper = 8'hFF; midi_left = 16'h0000; midi_right = 16'hFFFF;
        mix("midi_off", 0, 1535, 1534);
        specdrum = 8'hFF; midi_right = 16'h0000; ay1_cha = 1;
        mix("edge_2047", 0, 2047, 2047);
        ay1_cha = 2;
        mix("edge_2048", 0, 2047, 2047);
        ay1_cha = 0;
        mix("edge_2046", 0, 2046, 2046);
        clear_src();
        pan = 8'hC0; ay1_cha = 77;
        mix("snapshot", 1, 77, 77);
        clear_src();
        pan = 8'b10_01_11_11;
        ay1_cha = 100; ay2_cha = 50; ay1_chb = 20; ay1_chc = 10;
        nv = 0; first_v = -1; second_v = -1; nov = 0; ov_at = -1;
        for (int c = 0; c < 30; c++) begin
            sample_tick = (c == 0 || c == 3 || c == 5);
            @(negedge clk);
            if (out_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                else second_v = c;
            end
            if (overrun) begin
                nov++;
                ov_at = c;
            end
        end
        sample_tick = 1'b0;
        chk("b2b.valid_count", nv, 2);
        chk("b2b.first_valid", first_v, 10);
        chk("b2b.second_valid", second_v, 21);
        chk("b2b.overrun_count", nov, 1);
        chk("b2b.overrun_at", ov_at, 5);
        chk("b2b.left", out_left, 160);
        chk("b2b.right", out_right, 30);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid.busy_before", busy, 1);
        mrst = 1'b1;
        #1;
        chk("rst_mid.left", out_left, 0);
        chk("rst_mid.right", out_right, 0);
        chk("rst_mid.busy", busy, 0);
        @(negedge clk);
        mrst = 1'b0;
        nv = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("rst_mid.no_valid", nv, 0);
        mix("after_rst", 0, 160, 30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
